// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, LSB first.
// The operands are captured when start is accepted. WIDTH edges of SHIFT
// follow, then one DONE cycle that pulses done. The result ({cout,sum}) is
// held until the next completion.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input. When sub
// is high, the block computes a - b as a + ~b + 1.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter just wide enough to reach WIDTH-1 (WIDTH >= 2 keeps this >= 1).
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Datapath state
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    count_reg;

    // Control decode
    logic accept;
    logic shift_en;
    logic last_bit;

    // Capture-time values: B may be inverted and the carry forced when
    // subtracting.
    logic             sub_sel;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // One-bit full adder on the current LSBs
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] result_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Conditional per-bit inversion of B for subtraction
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_b_load
            assign b_load[gi] = b[gi] ^ sub_sel;
        end
    endgenerate

    // Two's-complement subtract needs the +1, and it overrides cin.
    assign carry_load = sub_sel ? 1'b1 : cin;

    assign accept   = (state_reg == IDLE) && start;
    assign shift_en = (state_reg == SHIFT);
    assign last_bit = shift_en && (count_reg == LAST_COUNT);

    assign bit_sum     = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign bit_carry   = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
    assign result_next = {bit_sum, result_reg[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always lasts one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_reg == LAST_COUNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand shift registers: load on accept, shift right each SHIFT edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b_load;
        end else if (shift_en) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
        end
    end

    // Carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else if (accept) begin
            carry_reg <= carry_load;
            count_reg <= '0;
        end else if (shift_en) begin
            carry_reg <= bit_carry;
            count_reg <= count_reg + CW'(1);
        end
    end

    // Result shift register: each new sum bit enters at the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
        end else if (shift_en) begin
            result_reg <= result_next;
        end
    end

    // Published result: updated only on the edge entering DONE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (last_bit) begin
            sum_reg  <= result_next;
            cout_reg <= bit_carry;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8). The driver pushes the
// expected {cout,sum} when it issues start. The monitor pops and compares on
// every done pulse. Subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] last_result;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got {cout,sum}=0x%0h, expected no done", {cout, sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, cout, sum}, {23'd0, e});
                $display("txn: done {cout,sum}=0x%03h expected 0x%03h", {cout, sum}, e);
            end
        end
    end

    // Issue one operation. Call this right after a negedge. It returns at the
    // 10th negedge after the accepting edge, with the DUT back in IDLE.
    // A nonzero poke_at pulses start (with a=b=1) at that SHIFT cycle.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic sv, input logic [8:0] expv, input int poke_at,
                          input string tag);
        int busy_cycles;
        int done_at;
        int pulses;
        logic busy_end;
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        exp_q.push_back(expv);
        busy_cycles = 0; done_at = 0; pulses = 0; busy_end = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Scramble the inputs after capture: the result must not change.
                a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
                check({tag, "_hold"}, {23'd0, cout, sum}, {23'd0, last_result});
            end
            if (i <= 9 && busy) busy_cycles++;
            if (i == 10) busy_end = busy;
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = i;
            end
            if (i == poke_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_busy_cycles"}, busy_cycles, 9);
        check({tag, "_busy_end"}, {31'd0, busy_end}, 0);
        check({tag, "_done_cycle"}, done_at, 9);
        check({tag, "_done_pulses"}, pulses, 1);
        $display("txn %s: a=0x%02h b=0x%02h cin=%0b sub=%0b -> {cout,sum}=0x%03h", tag, av, bv, cv, sv, {cout, sum});
        last_result = expv;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        last_result = '0;
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum",  {24'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start on the first edge after reset release.
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0, "ff_plus_1");
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 0, "a5_5a_cin");
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 9'h101, 0, "msb_carry");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 0, "ripple");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0, "all_ones");
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 3, "start_ignored");

        // Abandon an operation by asserting reset in its 4th SHIFT cycle.
        a = 8'h55; b = 8'h33; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_done", {31'd0, done}, 0);
        check("midreset_sum",  {24'd0, sum}, 0);
        check("midreset_cout", {31'd0, cout}, 0);
        $display("txn midreset: operation abandoned");
        last_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 0, "after_reset");

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0, "sub_no_borrow");
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 9'h0FF, 0, "sub_borrow");
        run_op(8'h20, 8'h03, 1'b1, 1'b0, 9'h024, 0, "sub_off_add");
`endif

        // Idle for a few cycles: there must be no stray done, and the result must hold.
        repeat (4) @(negedge clk);
        check("idle_hold", {23'd0, cout, sum}, {23'd0, last_result});
        check("queue_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk SHALL be a 1-bit input: the system clock, with all state updated on its rising edge.
REQ-004 Port rst_n SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-005 Port start SHALL be a 1-bit input: request to begin an addition; it is sampled only in IDLE.
REQ-006 Port a SHALL be a WIDTH-bit input: operand A, captured on the edge that accepts start.
REQ-007 Port b SHALL be a WIDTH-bit input: operand B, captured on the edge that accepts start.
REQ-008 Port cin SHALL be a 1-bit input: carry-in, captured on the edge that accepts start.
REQ-009 Port busy SHALL be a 1-bit output: high while in SHIFT or DONE.
REQ-010 Port done SHALL be a 1-bit output: a one-cycle pulse indicating that the result is valid.
REQ-011 Port sum SHALL be a WIDTH-bit output: the registered result, held until the next completion.
REQ-012 Port cout SHALL be a 1-bit output: the registered final carry, held with sum.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 SHALL, on that edge: capture a, b and cin; clear the bit counter; and go to SHIFT.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 Each SHIFT edge SHALL perform a one-bit full add of A[0], B[0] and the carry flop, LSB first:
- the sum bit is shifted into the MSB of the result shift register;
- A and B are shifted right;
- the carry flop takes the bit carry;
- the counter increments.
REQ-017 The SHIFT edge that processes bit WIDTH-1 SHALL load sum from the result register and cout from the final carry, and go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: when start is accepted at edge t0, done SHALL be high during the cycle following edge t0+WIDTH; the next start SHALL be accepted no earlier than edge t0+WIDTH+1.
REQ-020 start while in SHIFT or DONE SHALL be ignored, with no effect on the operation in flight or on the captured operands.
REQ-021 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-022 sum and cout SHALL change only on the edge entering DONE, and SHALL hold across IDLE.
REQ-023 The result SHALL equal {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no overflow beyond cout SHALL exist.

Reset
REQ-024 rst_n=0 SHALL immediately force:
- the state to IDLE;
- busy=0, done=0, sum=0, cout=0;
- the counter, carry flop and all shift registers to 0.
REQ-025 Reset asserted mid-SHIFT SHALL abandon the operation, and no done pulse SHALL be produced for it.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add a 1-bit input port sub, captured with the operands.
REQ-028 With SERIAL_ADDER_SUB_EN defined and sub=1, capture SHALL store ~b and force the carry flop to 1, ignoring cin, so that {cout,sum} = a + ~b + 1 (cout=1 means no borrow).
REQ-029 With SERIAL_ADDER_SUB_EN defined and sub=0, the block SHALL behave exactly as without the macro.
REQ-030 Without SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and the block SHALL only add.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: a=0x00, b=0x00, cin=0, start -> done 8 cycles after the start edge, sum=0x00, cout=0, busy high for 9 cycles.
REQ-032 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-033 The bench SHALL cover: start pulsed with a=0x01, b=0x01 during SHIFT of an operation with a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0, with a single done pulse.
REQ-034 The bench SHALL cover: rst_n pulsed low at the 4th SHIFT cycle -> all outputs 0, no done; a new operation with a=0x0F, b=0x01, cin=0 then gives sum=0x10.
REQ-035 The bench SHALL cover, with SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; and a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
